// File: rtl/product_accumulator_if.sv
// ---------------------------------------------------------------------------
// product_accumulator_if : product-in / result-out handshake bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface product_accumulator_if #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 12,
  parameter int BURST  = 4
);
  localparam int CNT_W = $clog2(BURST + 1);

  logic              prod_valid;
  logic              prod_ready;
  logic [PROD_W-1:0] prod_data;
  logic              flush;
  logic              res_valid;
  logic              res_ready;
  logic [ACC_W-1:0]  res_data;
  logic [CNT_W-1:0]  res_count;
  logic              res_ovf;

  modport master (
    output prod_valid, prod_data, flush, res_ready,
    input  prod_ready, res_valid, res_data, res_count, res_ovf
  );

  modport slave (
    input  prod_valid, prod_data, flush, res_ready,
    output prod_ready, res_valid, res_data, res_count, res_ovf
  );
endinterface

`default_nettype wire

// File: rtl/product_accumulator.sv
// ---------------------------------------------------------------------------
// product_accumulator : sums BURST multiplier products into one ACC_W result.
// SATURATE_EN clamps the sum on overflow instead of wrapping. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module product_accumulator #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 12,
  parameter int BURST  = 4
) (
  input  wire logic               clk,
  input  wire logic               rst,
  product_accumulator_if.slave    bus
);

  localparam int                 CNT_W   = $clog2(BURST + 1);
  localparam logic [CNT_W-1:0]   C_BURST = CNT_W'(BURST);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d, acc_upd;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_upd;
  logic               ovf_q, ovf_d, ovf_upd;
  logic [ACC_W-1:0]   res_data_q, res_data_d;
  logic [CNT_W-1:0]   res_count_q, res_count_d;
  logic               res_ovf_q, res_ovf_d;

  logic [ACC_W:0]     sum;
  logic               accept;
  logic               close;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    res_data_d  = res_data_q;
    res_count_d = res_count_q;
    res_ovf_d   = res_ovf_q;

    accept  = bus.prod_valid && (state_q == ST_ACCUM);
    sum     = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, bus.prod_data};
    ovf_upd = ovf_q | (accept & sum[ACC_W]);
    cnt_upd = accept ? cnt_q + CNT_W'(1) : cnt_q;
    acc_upd = accept ? sum[ACC_W-1:0] : acc_q;
`ifdef SATURATE_EN
    // Once the burst has overflowed, pin the sum at full scale for the rest of it.
    if (ovf_upd) acc_upd = '1;
`endif
    close = (accept && (cnt_upd == C_BURST)) ||
            (bus.flush && ((cnt_q != '0) || accept));

    case (state_q)
      ST_ACCUM: begin
        if (close) begin
          res_data_d  = acc_upd;
          res_count_d = cnt_upd;
          res_ovf_d   = ovf_upd;
          acc_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
          state_d     = ST_HOLD;
        end else begin
          acc_d = acc_upd;
          cnt_d = cnt_upd;
          ovf_d = ovf_upd;
        end
      end
      ST_HOLD: begin
        if (bus.res_ready) state_d = ST_ACCUM;
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      res_data_q  <= '0;
      res_count_q <= '0;
      res_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      res_data_q  <= res_data_d;
      res_count_q <= res_count_d;
      res_ovf_q   <= res_ovf_d;
    end
  end

  // Handshake flags decode straight from state so reset clears them without a clock.
  assign bus.prod_ready = (state_q == ST_ACCUM);
  assign bus.res_valid  = (state_q == ST_HOLD);
  assign bus.res_data   = res_data_q;
  assign bus.res_count  = res_count_q;
  assign bus.res_ovf    = res_ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_product_accumulator.sv
// ---------------------------------------------------------------------------
// tb_product_accumulator : directed vectors for product_accumulator
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_product_accumulator;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  product_accumulator_if #(.PROD_W(8), .ACC_W(12), .BURST(4)) u_if_main ();
  product_accumulator_if #(.PROD_W(8), .ACC_W(9),  .BURST(4)) u_if_ovf  ();
  product_accumulator_if #(.PROD_W(8), .ACC_W(12), .BURST(1)) u_if_b1   ();

  product_accumulator #(.PROD_W(8), .ACC_W(12), .BURST(4)) u_dut_main (
    .clk (clk), .rst (rst), .bus (u_if_main)
  );
  product_accumulator #(.PROD_W(8), .ACC_W(9), .BURST(4)) u_dut_ovf (
    .clk (clk), .rst (rst), .bus (u_if_ovf)
  );
  product_accumulator #(.PROD_W(8), .ACC_W(12), .BURST(1)) u_dut_b1 (
    .clk (clk), .rst (rst), .bus (u_if_b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic [7:0] d,
                       input logic f, input logic r);
    case (sel)
      0: begin
        u_if_main.prod_valid = v; u_if_main.prod_data = d;
        u_if_main.flush = f;      u_if_main.res_ready = r;
      end
      1: begin
        u_if_ovf.prod_valid = v;  u_if_ovf.prod_data = d;
        u_if_ovf.flush = f;       u_if_ovf.res_ready = r;
      end
      default: begin
        u_if_b1.prod_valid = v;   u_if_b1.prod_data = d;
        u_if_b1.flush = f;        u_if_b1.res_ready = r;
      end
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int sel, input logic [7:0] d);
    drive(sel, 1'b1, d, 1'b0, 1'b0);
    step();
    drive(sel, 1'b0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic pop(input int sel);
    drive(sel, 1'b0, 8'd0, 1'b0, 1'b1);
    step();
    drive(sel, 1'b0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic flush_only(input int sel);
    drive(sel, 1'b0, 8'd0, 1'b1, 1'b0);
    step();
    drive(sel, 1'b0, 8'd0, 1'b0, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    for (int s = 0; s < 3; s++) drive(s, 1'b0, 8'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_res_valid",  u_if_main.res_valid,  0);
    check("rst_res_data",   u_if_main.res_data,   0);
    check("rst_res_count",  u_if_main.res_count,  0);
    check("rst_res_ovf",    u_if_main.res_ovf,    0);
    check("rst_prod_ready", u_if_main.prod_ready, 1);

    // Full burst: 6+15+225+0 = 246
    send(0, 8'd6); send(0, 8'd15); send(0, 8'd225); send(0, 8'd0);
    check("full_valid", u_if_main.res_valid,  1);
    check("full_data",  u_if_main.res_data,   246);
    check("full_count", u_if_main.res_count,  4);
    check("full_ovf",   u_if_main.res_ovf,    0);
    check("full_ready", u_if_main.prod_ready, 0);

    // Back-pressure: producer keeps offering 9 while the result is held
    for (int i = 0; i < 5; i++) begin
      drive(0, 1'b1, 8'd9, 1'b0, 1'b0);
      step();
      check("bp_ready", u_if_main.prod_ready, 0);
      check("bp_data",  u_if_main.res_data,   246);
      check("bp_valid", u_if_main.res_valid,  1);
    end
    drive(0, 1'b1, 8'd9, 1'b0, 1'b1);
    step();
    check("bp_release_valid", u_if_main.res_valid,  0);
    check("bp_release_ready", u_if_main.prod_ready, 1);
    check("bp_keep_data",     u_if_main.res_data,   246);
    drive(0, 1'b1, 8'd9, 1'b0, 1'b0);
    repeat (3) begin
      step();
      check("bp_no_early", u_if_main.res_valid, 0);
    end
    step();
    drive(0, 1'b0, 8'd0, 1'b0, 1'b0);
    check("bp_burst_valid", u_if_main.res_valid, 1);
    check("bp_burst_data",  u_if_main.res_data,  36);
    check("bp_burst_count", u_if_main.res_count, 4);
    pop(0);

    // Flush after two products
    send(0, 8'd10); send(0, 8'd20);
    flush_only(0);
    check("flush_valid", u_if_main.res_valid, 1);
    check("flush_data",  u_if_main.res_data,  30);
    check("flush_count", u_if_main.res_count, 2);
    pop(0);

    // Flush on an empty burst is ignored
    flush_only(0);
    check("flush_empty_valid", u_if_main.res_valid, 0);
    step();
    check("flush_empty_valid2", u_if_main.res_valid, 0);

    // Flush concurrent with an accept
    send(0, 8'd10);
    drive(0, 1'b1, 8'd5, 1'b1, 1'b0);
    step();
    drive(0, 1'b0, 8'd0, 1'b0, 1'b0);
    check("flush_acc_valid", u_if_main.res_valid, 1);
    check("flush_acc_data",  u_if_main.res_data,  15);
    check("flush_acc_count", u_if_main.res_count, 2);
    pop(0);

    // Asynchronous reset while holding a result
    send(0, 8'd7);
    flush_only(0);
    check("hold_valid", u_if_main.res_valid, 1);
    #3 rst = 1'b1;
    #1;
    check("arst_valid", u_if_main.res_valid,  0);
    check("arst_ready", u_if_main.prod_ready, 1);
    check("arst_data",  u_if_main.res_data,   0);
    check("arst_count", u_if_main.res_count,  0);
    check("arst_ovf",   u_if_main.res_ovf,    0);
    @(posedge clk);
    #1 rst = 1'b0;
    send(0, 8'd1); send(0, 8'd2); send(0, 8'd3); send(0, 8'd4);
    check("post_rst_valid", u_if_main.res_valid, 1);
    check("post_rst_data",  u_if_main.res_data,  10);
    pop(0);

    // Overflow on a 9-bit accumulator: 225*3+1 = 676
    send(1, 8'd225); send(1, 8'd225); send(1, 8'd225); send(1, 8'd1);
    check("ovf_valid", u_if_ovf.res_valid, 1);
`ifdef SATURATE_EN
    check("ovf_data",  u_if_ovf.res_data,  511);
`else
    check("ovf_data",  u_if_ovf.res_data,  164);
`endif
    check("ovf_flag",  u_if_ovf.res_ovf,   1);
    check("ovf_count", u_if_ovf.res_count, 4);
    pop(1);
    send(1, 8'd1); send(1, 8'd2); send(1, 8'd3); send(1, 8'd4);
    check("clean_data", u_if_ovf.res_data, 10);
    check("clean_ovf",  u_if_ovf.res_ovf,  0);
    pop(1);

    // BURST=1: every accept yields a result
    send(2, 8'd5);
    check("b1_valid", u_if_b1.res_valid, 1);
    check("b1_data",  u_if_b1.res_data,  5);
    check("b1_count", u_if_b1.res_count, 1);
    pop(2);
    send(2, 8'd200);
    check("b1_data2", u_if_b1.res_data, 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
